pdm_decimator_1000x: RTL

PDM_DECIMATOR_1000X -- requirements
Module: pdm_decimator_1000x

---
 rtl/pdm_decimator_1000x.sv | 126 ++++++++++++
 1 files changed

// File: rtl/pdm_decimator_1000x.sv
// Third-order CIC decimator turning a 1-bit PDM stream into unsigned samples.
// Integrators run on clk_en edges; the comb pipeline runs every clock after a tick.
module pdm_decimator_1000x #(
  parameter int DECIMATION   = 1000,
  parameter int OUTPUT_WIDTH = 8,
  parameter int ACC_WIDTH    = 30
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clk_en,
  input  logic                    pdm_in,
  input  logic                    sync,
  output logic [OUTPUT_WIDTH-1:0] sample_out,
  output logic                    sample_valid
);

  localparam int CW = (DECIMATION > 1) ? $clog2(DECIMATION) : 1;
  localparam logic [CW-1:0] LAST_PHASE = CW'(DECIMATION - 1);

  logic [ACC_WIDTH-1:0]    i1_q, i1_d, i2_q, i2_d, i3_q, i3_d;
  logic [ACC_WIDTH-1:0]    c1_q, c1_d, c2_q, c2_d, c3_q, c3_d;
  logic [ACC_WIDTH-1:0]    dl0_q, dl0_d, dl1_q, dl1_d, dl2_q, dl2_d;
  logic [CW-1:0]           dec_cnt_q, dec_cnt_d;
  logic                    tick_q, tick_d;
  logic                    v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  logic [OUTPUT_WIDTH-1:0] sample_out_q, sample_out_d;
  logic                    sample_valid_q, sample_valid_d;

  always_comb begin
    i1_d           = i1_q;
    i2_d           = i2_q;
    i3_d           = i3_q;
    dec_cnt_d      = dec_cnt_q;
    tick_d         = 1'b0;
    c1_d           = c1_q;
    c2_d           = c2_q;
    c3_d           = c3_q;
    dl0_d          = dl0_q;
    dl1_d          = dl1_q;
    dl2_d          = dl2_q;
    sample_out_d   = sample_out_q;

    if (clk_en) begin
      i1_d = i1_q + {{(ACC_WIDTH-1){1'b0}}, pdm_in};
      i2_d = i2_q + i1_q;
      i3_d = i3_q + i2_q;
    end

    // sync realigns the phase and swallows any wrap on the same edge
    if (sync) begin
      dec_cnt_d = '0;
    end else if (clk_en) begin
      if (dec_cnt_q == LAST_PHASE) begin
        dec_cnt_d = '0;
        tick_d    = 1'b1;
      end else begin
        dec_cnt_d = dec_cnt_q + CW'(1);
      end
    end

    v1_d = tick_q;
    if (tick_q) begin
      c1_d  = i3_q - dl0_q;
      dl0_d = i3_q;
    end

    v2_d = v1_q;
    if (v1_q) begin
      c2_d  = c1_q - dl1_q;
      dl1_d = c1_q;
    end

    v3_d = v2_q;
    if (v2_q) begin
      c3_d  = c2_q - dl2_q;
      dl2_d = c2_q;
    end

    sample_valid_d = v3_q;
    if (v3_q) begin
      sample_out_d = c3_q[ACC_WIDTH-1 -: OUTPUT_WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      i1_q           <= '0;
      i2_q           <= '0;
      i3_q           <= '0;
      c1_q           <= '0;
      c2_q           <= '0;
      c3_q           <= '0;
      dl0_q          <= '0;
      dl1_q          <= '0;
      dl2_q          <= '0;
      dec_cnt_q      <= '0;
      tick_q         <= 1'b0;
      v1_q           <= 1'b0;
      v2_q           <= 1'b0;
      v3_q           <= 1'b0;
      sample_out_q   <= '0;
      sample_valid_q <= 1'b0;
    end else begin
      i1_q           <= i1_d;
      i2_q           <= i2_d;
      i3_q           <= i3_d;
      c1_q           <= c1_d;
      c2_q           <= c2_d;
      c3_q           <= c3_d;
      dl0_q          <= dl0_d;
      dl1_q          <= dl1_d;
      dl2_q          <= dl2_d;
      dec_cnt_q      <= dec_cnt_d;
      tick_q         <= tick_d;
      v1_q           <= v1_d;
      v2_q           <= v2_d;
      v3_q           <= v3_d;
      sample_out_q   <= sample_out_d;
      sample_valid_q <= sample_valid_d;
    end
  end

  assign sample_out   = sample_out_q;
  assign sample_valid = sample_valid_q;

endmodule
